// File: rtl/npu_spm_defines.sv
// Shared definitions for the scratchpad replay path: lane count and replay FSM states.
package npu_spm_defines;

    localparam int SM_PROCESSING_ELEMENTS = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } spm_replay_state_t;

endpackage

// File: rtl/spm_replay_controller.sv
// Replays a multi-lane scratchpad request over successive iterations until
// every active lane has been served by the external conflict decision logic.
//
// state  | meaning
// IDLE   | waiting for a request; in_ready high
// REPLAY | pending_mask is issued every cycle until it drains to zero
module spm_replay_controller
    import npu_spm_defines::*;
#(
    parameter  int LANES = SM_PROCESSING_ELEMENTS,
    localparam int CW    = $clog2(LANES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [LANES-1:0] in_mask,
    output logic             in_ready,
    input  logic [LANES-1:0] satisfied_mask,
    input  logic             issue_stall,
    output logic [LANES-1:0] pending_mask,
    output logic             issue_valid,
    output logic             first_iteration,
    output logic             last_iteration,
    output logic             done_valid,
    output logic [CW-1:0]    iteration_count,
    output logic             protocol_error
);

    spm_replay_state_t state;
    logic [CW-1:0]     counter;
    logic [LANES-1:0]  served;
    logic [LANES-1:0]  remaining;
    logic [CW-1:0]     counter_next;

    assign served       = pending_mask & satisfied_mask;
    assign remaining    = pending_mask & ~satisfied_mask;
    assign counter_next = (counter == {CW{1'b1}}) ? counter : counter + 1'b1;

    assign in_ready       = (state == IDLE);
    assign last_iteration = issue_valid && !issue_stall && (remaining == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            pending_mask    <= '0;
            issue_valid     <= 1'b0;
            first_iteration <= 1'b0;
            done_valid      <= 1'b0;
            iteration_count <= '0;
            protocol_error  <= 1'b0;
            counter         <= '0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_mask == '0) begin
                            done_valid      <= 1'b1;
                            iteration_count <= '0;
                        end else begin
                            state           <= REPLAY;
                            pending_mask    <= in_mask;
                            issue_valid     <= 1'b1;
                            first_iteration <= 1'b1;
                            counter         <= '0;
                        end
                    end
                end
                REPLAY: begin
                    if (!issue_stall) begin
                        // No lane served means the decision logic made no progress; hold and flag.
                        if (served == '0) begin
                            protocol_error <= 1'b1;
                        end else begin
                            pending_mask    <= remaining;
                            counter         <= counter_next;
                            first_iteration <= 1'b0;
                            if (remaining == '0) begin
                                state           <= IDLE;
                                issue_valid     <= 1'b0;
                                done_valid      <= 1'b1;
                                iteration_count <= counter_next;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_replay_controller.sv
// Directed and randomized checks of spm_replay_controller against a lane-set model.
module tb_spm_replay_controller;

    localparam int LANES = 16;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [LANES-1:0] in_mask;
    logic             in_ready;
    logic [LANES-1:0] satisfied_mask;
    logic             issue_stall;
    logic [LANES-1:0] pending_mask;
    logic             issue_valid;
    logic             first_iteration;
    logic             last_iteration;
    logic             done_valid;
    logic [CW-1:0]    iteration_count;
    logic             protocol_error;

    int tests = 0;
    int fails = 0;

    spm_replay_controller #(.LANES(LANES)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_mask         (in_mask),
        .in_ready        (in_ready),
        .satisfied_mask  (satisfied_mask),
        .issue_stall     (issue_stall),
        .pending_mask    (pending_mask),
        .issue_valid     (issue_valid),
        .first_iteration (first_iteration),
        .last_iteration  (last_iteration),
        .done_valid      (done_valid),
        .iteration_count (iteration_count),
        .protocol_error  (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout global time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LANES-1:0] exp_pending, sub, extra, m, low;
        int               exp_iters, cycles, done_seen;
        logic             exp_first, stall_now;

        reset = 1'b0; in_valid = 1'b0; in_mask = '0; satisfied_mask = '0; issue_stall = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_pending", pending_mask, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_iter", iteration_count, 0);
        chk("rst_err", protocol_error, 0);
        chk("rst_first", first_iteration, 0);
        tick();
        reset = 1'b1;

        // Two iterations: 0x00FF served as 0x000F then 0x00F0
        in_valid = 1'b1; in_mask = 16'h00FF;
        tick();
        in_valid = 1'b0; satisfied_mask = 16'h000F; #1;
        chk("t1_issue", issue_valid, 1);
        chk("t1_pending0", pending_mask, 16'h00FF);
        chk("t1_first0", first_iteration, 1);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_last0", last_iteration, 0);
        chk("t1_done0", done_valid, 0);
        tick();
        satisfied_mask = 16'h00F0; #1;
        chk("t1_pending1", pending_mask, 16'h00F0);
        chk("t1_first1", first_iteration, 0);
        chk("t1_last1", last_iteration, 1);
        tick();
        satisfied_mask = '0; #1;
        chk("t1_done", done_valid, 1);
        chk("t1_iter", iteration_count, 2);
        chk("t1_issue_end", issue_valid, 0);
        chk("t1_ready_end", in_ready, 1);

        // Empty request accepted back-to-back in the done cycle
        in_valid = 1'b1; in_mask = 16'h0000;
        tick(); #1;
        chk("t2_done", done_valid, 1);
        chk("t2_iter", iteration_count, 0);
        chk("t2_issue", issue_valid, 0);

        // Single lane with three stalled cycles
        in_mask = 16'h0001;
        tick();
        in_valid = 1'b0; issue_stall = 1'b1; satisfied_mask = 16'hFFFF; #1;
        chk("t3_done_clr", done_valid, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin tick(); #1; end
            chk("t3_stall_pending", pending_mask, 16'h0001);
            chk("t3_stall_first", first_iteration, 1);
            chk("t3_stall_last", last_iteration, 0);
        end
        tick();
        issue_stall = 1'b0; satisfied_mask = 16'h0001; #1;
        chk("t3_pending", pending_mask, 16'h0001);
        chk("t3_last", last_iteration, 1);
        chk("t3_err", protocol_error, 0);
        tick(); #1;
        chk("t3_done", done_valid, 1);
        chk("t3_iter", iteration_count, 1);

        // Oversatisfied: bits outside pending are ignored
        in_valid = 1'b1; in_mask = 16'h0003;
        tick();
        in_valid = 1'b0; satisfied_mask = 16'hFFFF; #1;
        chk("t4_pending", pending_mask, 16'h0003);
        chk("t4_last", last_iteration, 1);
        tick(); #1;
        chk("t4_done", done_valid, 1);
        chk("t4_iter", iteration_count, 1);

        // No forward progress sets a sticky error
        in_valid = 1'b1; in_mask = 16'h0010;
        tick();
        in_valid = 1'b0; satisfied_mask = 16'h0000; #1;
        chk("t5_last", last_iteration, 0);
        chk("t5_err0", protocol_error, 0);
        tick(); #1;
        chk("t5_err1", protocol_error, 1);
        chk("t5_pending", pending_mask, 16'h0010);
        chk("t5_issue", issue_valid, 1);
        satisfied_mask = 16'h0010; #1;
        chk("t5_last2", last_iteration, 1);
        tick(); #1;
        chk("t5_done", done_valid, 1);
        chk("t5_err_sticky", protocol_error, 1);

        // Asynchronous reset in the middle of a replay
        in_valid = 1'b1; in_mask = 16'h0F00;
        tick();
        in_valid = 1'b0; issue_stall = 1'b1; satisfied_mask = '0; #1;
        chk("t6_pending", pending_mask, 16'h0F00);
        #1 reset = 1'b0; #1;
        chk("t6_pending_rst", pending_mask, 0);
        chk("t6_issue_rst", issue_valid, 0);
        chk("t6_first_rst", first_iteration, 0);
        chk("t6_done_rst", done_valid, 0);
        chk("t6_iter_rst", iteration_count, 0);
        chk("t6_err_rst", protocol_error, 0);
        chk("t6_ready_rst", in_ready, 1);
        tick();
        reset = 1'b1; issue_stall = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_valid) done_seen++;
        end
        chk("t6_no_done", done_seen, 0);
        chk("t6_ready_after", in_ready, 1);
        chk("t6_issue_after", issue_valid, 0);

        // Randomized requests, each offered in the cycle the previous one finishes
        for (int t = 0; t < 60; t++) begin
            m = ($urandom_range(0, 7) == 0) ? '0 : LANES'($urandom);
            chk("rnd_ready", in_ready, 1);
            in_valid = 1'b1; in_mask = m;
            tick();
            in_valid = 1'b0; in_mask = '0;
            exp_pending = m; exp_iters = 0; exp_first = 1'b1; cycles = 0;
            while (exp_pending != '0) begin
                stall_now = ($urandom_range(0, 3) == 0);
                sub = exp_pending & LANES'($urandom);
                if (sub == '0) begin
                    low = exp_pending & (~exp_pending + 1'b1);
                    sub = low;
                end
                extra = LANES'($urandom) & ~exp_pending;
                issue_stall = stall_now; satisfied_mask = sub | extra; #1;
                chk("rnd_issue", issue_valid, 1);
                chk("rnd_pending", pending_mask, exp_pending);
                chk("rnd_first", first_iteration, exp_first);
                chk("rnd_last", last_iteration,
                    (!stall_now && ((exp_pending & ~(sub | extra)) == '0)) ? 1 : 0);
                if (!stall_now) begin
                    exp_pending = exp_pending & ~sub;
                    exp_iters++;
                    exp_first = 1'b0;
                end
                tick();
                cycles++;
                if (cycles > 200) begin
                    chk("rnd_cycle_budget", cycles, 0);
                    break;
                end
            end
            issue_stall = 1'b0; satisfied_mask = '0; #1;
            chk("rnd_done", done_valid, 1);
            chk("rnd_iter", iteration_count, exp_iters);
            chk("rnd_issue_end", issue_valid, 0);
        end
        chk("rnd_err", protocol_error, 0);

        // Between done pulses the count holds
        m = 16'h8001;
        in_valid = 1'b1; in_mask = m;
        tick();
        in_valid = 1'b0; satisfied_mask = 16'h0001; #1;
        tick();
        satisfied_mask = 16'h8000; #1;
        tick(); #1;
        chk("hold_done", done_valid, 1);
        tick(); tick(); #1;
        chk("hold_done_clr", done_valid, 0);
        chk("hold_iter", iteration_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
